// File: rtl/mem_arb_defs.sv
// Shared encodings for the memory bus arbiter: FSM states, owner codes and ROM page decode.
// Optional ROM write protection is selected with the MEM_ARB_ROM_WP_EN macro in mem_bus_arbiter.
package mem_arb_defs;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   localparam logic [7:0] ROM_PAGE = 8'h00;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } bus_req_t;

   // Region decode looks only at the page byte: 0x00FF is ROM, 0x0100 is RAM.
   function automatic logic is_rom(input logic [15:0] addr);
      return addr[15:8] == ROM_PAGE;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// CPU-priority requester pick with a saturating starvation counter that forces a DMA win.
module mem_arb_pick
   import mem_arb_defs::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic arbitrate,
   output logic winner
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   assign winner = (dma_req && (!cpu_req || starve_cnt == LIMIT)) ? OWNER_DMA : OWNER_CPU;

   // Counts CPU grants taken while DMA was also waiting; any grant without DMA contention clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (arbitrate) begin
         if (winner == OWNER_DMA || !dma_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU, DMA) arbiter and access sequencer for the shared ROM/RAM bus.
// Define MEM_ARB_ROM_WP_EN to suppress ROM-page write strobes and report them on rom_wr_err.
module mem_bus_arbiter
   import mem_arb_defs::*;
#(
   parameter int RAM_WAIT     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic [7:0]  dma_rdata,
   output logic        dma_ack,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic        owner,
   output logic        busy
`ifdef MEM_ARB_ROM_WP_EN
   ,
   output logic        rom_wr_err
`endif
);

   // Handshake: a requester raises req with stable we/addr/wdata and holds them until its
   // one-cycle ack; the request is latched at grant, so later input changes are ignored.

   localparam logic [3:0] RAM_WAIT_CNT = 4'(RAM_WAIT);

   logic [1:0] state;
   bus_req_t   lat;
   bus_req_t   win_req;
   logic [3:0] wait_cnt;
   logic       arbitrate;
   logic       winner;
   logic       wr_block;

   assign arbitrate = (state == IDLE) && (cpu_req || dma_req);

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk      (clk),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .dma_req  (dma_req),
      .arbitrate(arbitrate),
      .winner   (winner)
   );

   always_comb begin
      win_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
      if (winner == OWNER_DMA) begin
         win_req = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lat       <= '0;
         wait_cnt  <= '0;
         owner     <= OWNER_CPU;
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arbitrate) begin
                  lat      <= win_req;
                  owner    <= winner;
                  wait_cnt <= is_rom(win_req.addr) ? 4'd0 : RAM_WAIT_CNT;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt == 4'd0) begin
                  if (owner == OWNER_DMA) begin
                     dma_rdata <= mem_rdata;
                  end else begin
                     cpu_rdata <= mem_rdata;
                  end
                  state <= ACK;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_ROM_WP_EN
   assign wr_block   = is_rom(lat.addr);
   assign rom_wr_err = (state == ACK) && lat.we && is_rom(lat.addr);
`else
   assign wr_block = 1'b0;
`endif

   assign busy      = (state != IDLE);
   assign mem_addr  = lat.addr;
   assign mem_wdata = lat.wdata;
   assign mem_read  = (state == ACCESS) && !lat.we;
   assign mem_write = (state == ACCESS) && lat.we && !wr_block;
   assign cpu_ack   = (state == ACK) && (owner == OWNER_CPU);
   assign dma_ack   = (state == ACK) && (owner == OWNER_DMA);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: randomized CPU/DMA traffic against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int RAM_WAIT     = 2;
   localparam int STARVE_LIMIT = 4;
   localparam int EW           = 45;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [15:0] dma_addr = '0;
   logic [7:0]  dma_wdata = '0;
   logic [7:0]  dma_rdata;
   logic        dma_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_read, mem_write, owner, busy;
`ifdef MEM_ARB_ROM_WP_EN
   logic        rom_wr_err;
`endif

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   mem_bus_arbiter #(
      .RAM_WAIT    (RAM_WAIT),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .owner     (owner),
      .busy      (busy)
`ifdef MEM_ARB_ROM_WP_EN
      ,
      .rom_wr_err(rom_wr_err)
`endif
   );

   // Bus responder: read data is a fixed function of the address.
   function automatic logic [7:0] bus_data(input logic [15:0] a);
      if (a == 16'h0010) return 8'hA5;
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
   endfunction

   assign mem_rdata = bus_data(mem_addr);

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Entry: {rom_wr_err, port, we, addr[16], wdata[8], rdata[8], strobe_cycles[5], busy_cycles[5]}
   logic [EW-1:0] exp_q[$];
   int            starve = 0;
   logic          cpu_pend = 1'b0, dma_pend = 1'b0;
   bit            ack_log[$];

   function automatic logic [EW-1:0] make_exp(input logic port, input logic we,
                                              input logic [15:0] a, input logic [7:0] wd);
      int   wait_n;
      logic blocked;
      wait_n  = (a < 16'h0100) ? 0 : RAM_WAIT;
      blocked = 1'b0;
`ifdef MEM_ARB_ROM_WP_EN
      blocked = we && (a < 16'h0100);
`endif
      return {blocked, port, we, a, wd, bus_data(a),
              5'(blocked ? 0 : 1 + wait_n), 5'(2 + wait_n)};
   endfunction

   function automatic logic [15:0] rand_addr();
      if ($urandom_range(0, 2) == 0) return 16'($urandom_range(0, 255));
      return 16'($urandom_range(0, 65535));
   endfunction

   // ---------------- driver ----------------
   // One arbitration round: post new requests in IDLE, predict the grant, wait for its ack.
   task automatic run_round(input bit new_c, input bit new_d,
                            input logic c_we, input logic [15:0] c_a, input logic [7:0] c_wd,
                            input logic d_we, input logic [15:0] d_a, input logic [7:0] d_wd);
      logic win;
      bit   got;
      @(negedge clk);
      if (new_c && !cpu_pend) begin
         cpu_req = 1'b1; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_wd; cpu_pend = 1'b1;
      end
      if (new_d && !dma_pend) begin
         dma_req = 1'b1; dma_we = d_we; dma_addr = d_a; dma_wdata = d_wd; dma_pend = 1'b1;
      end
      if (!cpu_pend && !dma_pend) return;
      if (cpu_pend && dma_pend) begin
         if (starve == STARVE_LIMIT) begin win = 1'b1; starve = 0; end
         else begin win = 1'b0; starve++; end
      end else begin
         win = dma_pend;
         starve = 0;
      end
      if (win) exp_q.push_back(make_exp(1'b1, dma_we, dma_addr, dma_wdata));
      else     exp_q.push_back(make_exp(1'b0, cpu_we, cpu_addr, cpu_wdata));
      @(negedge clk);
      // The access is latched now; disturb the winner's inputs to prove they are ignored.
      if (win) begin dma_addr = 16'($urandom); dma_wdata = 8'($urandom); end
      else     begin cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = win ? dma_ack : cpu_ack;
      end
      check("ack_wait", 32'(got), 32'd1);
      if (win) begin dma_req = 1'b0; dma_pend = 1'b0; end
      else     begin cpu_req = 1'b0; cpu_pend = 1'b0; end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int            m_slen = 0, m_blen = 0;
   logic [15:0]   m_addr;
   logic [7:0]    m_wd;
   logic          m_we;
   logic          m_port;
   logic [EW-1:0] m_e;
   logic [7:0]    last_rd[2];

   always @(negedge clk) begin
      if (!reset) begin
         m_slen = 0; m_blen = 0;
         last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      end else begin
         if (busy) m_blen++;
         if (mem_read || mem_write) begin
            check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (!busy) check("strobe_while_idle", 32'd1, 32'd0);
            if (m_slen == 0) begin m_addr = mem_addr; m_wd = mem_wdata; m_we = mem_write; end
            m_slen++;
         end
`ifdef MEM_ARB_ROM_WP_EN
         if (rom_wr_err && !(cpu_ack || dma_ack)) check("rom_wr_err_without_ack", 32'd1, 32'd0);
`endif
         if (cpu_ack || dma_ack) begin
            check("single_ack", 32'(cpu_ack & dma_ack), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 32'd1, 32'd0);
            end else begin
               m_e    = exp_q.pop_front();
               m_port = m_e[43];
               check("ack_port", 32'(dma_ack), 32'(m_port));
               check("owner", 32'(owner), 32'(m_port));
               check("busy_cycles", 32'(m_blen), 32'(m_e[4:0]));
               check("strobe_cycles", 32'(m_slen), 32'(m_e[9:5]));
               if (m_slen != 0) begin
                  check("bus_addr", 32'(m_addr), 32'(m_e[41:26]));
                  check("bus_we", 32'(m_we), 32'(m_e[42]));
                  if (m_e[42]) check("bus_wdata", 32'(m_wd), 32'(m_e[25:18]));
               end
               check("rdata", 32'(m_port ? dma_rdata : cpu_rdata), 32'(m_e[17:10]));
               check("other_rdata_hold", 32'(m_port ? cpu_rdata : dma_rdata),
                     32'(last_rd[m_port ? 0 : 1]));
`ifdef MEM_ARB_ROM_WP_EN
               check("rom_wr_err", 32'(rom_wr_err), 32'(m_e[44]));
`endif
               last_rd[m_port ? 1 : 0] = m_e[17:10];
               ack_log.push_back(dma_ack);
            end
            m_slen = 0; m_blen = 0;
         end else if (!busy) begin
            m_slen = 0; m_blen = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [6:0] order_exp;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Reset during a RAM access: everything drops at once and no ack follows.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 8'h00;
      @(negedge clk);
      check("pre_reset_read_strobe", 32'(mem_read), 32'd1);
      reset = 1'b0;
      #1;
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
      check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      starve = 0;
      @(negedge clk);
      check("busy_after_reset", 32'(busy), 32'd0);

      // Both requesters held: CPU x4, DMA, CPU, then the waiting DMA.
      ack_log.delete();
      for (int i = 0; i < 6; i++)
         run_round(1'b1, 1'b1, 1'b0, 16'(16'h0020 + i), 8'h00, 1'b0, 16'h0300, 8'h00);
      run_round(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00);
      @(negedge clk);
      order_exp = 7'b1010000;
      check("grant_count", 32'(ack_log.size()), 32'd7);
      for (int i = 0; i < 7 && i < ack_log.size(); i++)
         check("grant_order", 32'(ack_log[i]), 32'(order_exp[i]));

      // Directed accesses: ROM read, DMA RAM write, region boundary, ROM write.
      run_round(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0000, 8'h00);
      run_round(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0100, 8'h3C);
      run_round(1'b1, 1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0, 16'h0000, 8'h00);
      run_round(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 16'h0000, 8'h00);
      run_round(1'b1, 1'b0, 1'b1, 16'h0005, 8'h77, 1'b0, 16'h0000, 8'h00);

      // Randomized mixed traffic.
      for (int i = 0; i < 150; i++)
         run_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rand_addr(), 8'($urandom),
                   1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));

      repeat (4) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
